// File: rtl/axi_lite_mem_bridge.sv
// axi_lite_mem_bridge: CPU strobe memory port to single-beat AXI4-Lite manager bridge
module axi_lite_mem_bridge #(
    parameter logic [2:0] PROT = 3'b000
) (
    input  logic        ACLK,
    input  logic        RESET,
    input  logic [31:0] CPU_ADDR,
    input  logic [31:0] CPU_WDATA,
    input  logic [1:0]  CPU_SIZE,
    input  logic        CPU_WRSTB,
    input  logic        CPU_RDSTB,
    output logic [31:0] CPU_RDATA,
    output logic        CPU_BUSY,
    output logic        CPU_ERR,
    output logic [31:0] M_AXI_AWADDR,
    output logic [2:0]  M_AXI_AWPROT,
    output logic        M_AXI_AWVALID,
    input  logic        M_AXI_AWREADY,
    output logic [31:0] M_AXI_WDATA,
    output logic [3:0]  M_AXI_WSTRB,
    output logic        M_AXI_WVALID,
    input  logic        M_AXI_WREADY,
    input  logic [1:0]  M_AXI_BRESP,
    input  logic        M_AXI_BVALID,
    output logic        M_AXI_BREADY,
    output logic [31:0] M_AXI_ARADDR,
    output logic [2:0]  M_AXI_ARPROT,
    output logic        M_AXI_ARVALID,
    input  logic        M_AXI_ARREADY,
    input  logic [31:0] M_AXI_RDATA,
    input  logic [1:0]  M_AXI_RRESP,
    input  logic        M_AXI_RVALID,
    output logic        M_AXI_RREADY
);
    typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP} state_t;
    state_t      state_q;
    logic [31:0] addr_q, wdata_q, rdata_q;
    logic [3:0]  wstrb_q;
    logic [1:0]  size_q;
    logic        awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q, aw_done_q, w_done_q;
    logic        req, mis, idle, wr_done, rd_done, aw_ok, w_ok;
    logic [31:0] shifted, rd_aligned, wdata_d;
    logic [3:0]  wstrb_d;

    always_comb begin
        req        = CPU_WRSTB | CPU_RDSTB;
        mis        = (CPU_SIZE == 2'd3) | ((CPU_SIZE == 2'd1) & CPU_ADDR[0]) | ((CPU_SIZE == 2'd2) & |CPU_ADDR[1:0]);
        idle       = state_q == IDLE;
        wr_done    = (state_q == WR_RESP) & M_AXI_BVALID;
        rd_done    = (state_q == RD_RESP) & M_AXI_RVALID;
        aw_ok      = aw_done_q | (awvalid_q & M_AXI_AWREADY);
        w_ok       = w_done_q | (wvalid_q & M_AXI_WREADY);
        shifted    = M_AXI_RDATA >> {addr_q[1:0], 3'b000};
        rd_aligned = size_q == 2'd0 ? shifted & 32'h0000_00FF :
                     size_q == 2'd1 ? shifted & 32'h0000_FFFF : M_AXI_RDATA;
        wstrb_d    = CPU_SIZE == 2'd0 ? 4'b0001 << CPU_ADDR[1:0] :
                     CPU_SIZE == 2'd1 ? 4'b0011 << {CPU_ADDR[1], 1'b0} : 4'b1111;
        wdata_d    = CPU_SIZE == 2'd0 ? {4{CPU_WDATA[7:0]}} :
                     CPU_SIZE == 2'd1 ? {2{CPU_WDATA[15:0]}} : CPU_WDATA;
        // busy drops in the completing cycle so the pipeline advances on that edge
        CPU_BUSY   = idle ? req & ~mis : ~(wr_done | rd_done);
        CPU_ERR    = (idle & req & mis) | (wr_done & |M_AXI_BRESP) | (rd_done & |M_AXI_RRESP);
        CPU_RDATA  = rd_done ? rd_aligned : (idle & CPU_RDSTB & mis) ? 32'd0 : rdata_q;
    end

    always_ff @(posedge ACLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            wstrb_q   <= '0;
            size_q    <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (req & ~mis) begin
                    addr_q <= CPU_ADDR;
                    size_q <= CPU_SIZE;
                    if (CPU_WRSTB) begin
                        wdata_q   <= wdata_d;
                        wstrb_q   <= wstrb_d;
                        awvalid_q <= 1'b1;
                        wvalid_q  <= 1'b1;
                        state_q   <= WR_REQ;
                    end else begin
                        arvalid_q <= 1'b1;
                        state_q   <= RD_REQ;
                    end
                end
                WR_REQ: begin
                    if (awvalid_q & M_AXI_AWREADY) begin
                        awvalid_q <= 1'b0;
                        aw_done_q <= 1'b1;
                    end
                    if (wvalid_q & M_AXI_WREADY) begin
                        wvalid_q <= 1'b0;
                        w_done_q <= 1'b1;
                    end
                    if (aw_ok & w_ok) begin
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                        bready_q  <= 1'b1;
                        state_q   <= WR_RESP;
                    end
                end
                WR_RESP: if (M_AXI_BVALID) begin
                    bready_q <= 1'b0;
                    state_q  <= IDLE;
                end
                RD_REQ: if (M_AXI_ARREADY) begin
                    arvalid_q <= 1'b0;
                    rready_q  <= 1'b1;
                    state_q   <= RD_RESP;
                end
                RD_RESP: if (M_AXI_RVALID) begin
                    rready_q <= 1'b0;
                    rdata_q  <= rd_aligned;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_AWPROT  = PROT;
    assign M_AXI_ARPROT  = PROT;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = wstrb_q;
    assign M_AXI_BREADY  = bready_q;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_RREADY  = rready_q;
endmodule

// File: tb/tb_axi_lite_mem_bridge.sv
// tb_axi_lite_mem_bridge: scoreboard bench with a behavioural AXI-Lite subordinate
module tb_axi_lite_mem_bridge;
    logic        ACLK = 1'b0, RESET = 1'b1;
    logic [31:0] CPU_ADDR = '0, CPU_WDATA = '0, CPU_RDATA;
    logic [1:0]  CPU_SIZE = '0;
    logic        CPU_WRSTB = 1'b0, CPU_RDSTB = 1'b0, CPU_BUSY, CPU_ERR;
    logic [31:0] M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR, M_AXI_RDATA = '0;
    logic [2:0]  M_AXI_AWPROT, M_AXI_ARPROT;
    logic [3:0]  M_AXI_WSTRB;
    logic [1:0]  M_AXI_BRESP = '0, M_AXI_RRESP = '0;
    logic        M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY;
    logic        M_AXI_AWREADY = 1'b0, M_AXI_WREADY = 1'b0, M_AXI_BVALID = 1'b0;
    logic        M_AXI_ARREADY = 1'b0, M_AXI_RVALID = 1'b0;

    axi_lite_mem_bridge dut (
        .ACLK(ACLK), .RESET(RESET),
        .CPU_ADDR(CPU_ADDR), .CPU_WDATA(CPU_WDATA), .CPU_SIZE(CPU_SIZE),
        .CPU_WRSTB(CPU_WRSTB), .CPU_RDSTB(CPU_RDSTB),
        .CPU_RDATA(CPU_RDATA), .CPU_BUSY(CPU_BUSY), .CPU_ERR(CPU_ERR),
        .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
        .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
        .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
        .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
        .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
        .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
        .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
        .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
    );

    always #5 ACLK = ~ACLK;

    typedef struct {logic err; logic ld; logic [31:0] rdata;} cpu_t;
    logic [31:0] aw_q[$], ar_q[$];
    logic [35:0] w_q[$];
    cpu_t        cpu_q[$];
    int total = 0, bad = 0;
    int aw_cyc = 0, w_cyc = 0;
    int aw_wait = 0, w_wait = 0, ar_wait = 0, b_wait = 0, r_wait = 0;
    logic [1:0]  bresp_c = 2'd0, rresp_c = 2'd0;
    logic [31:0] rdata_c = '0;

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    task automatic unexpected(input string n);
        total++;
        bad++;
        $display("FAIL %s: got an unexpected event, expected none", n);
    endtask

    task automatic exp_cpu(input logic err, input logic ld, input logic [31:0] rd);
        cpu_t e;
        e.err = err;
        e.ld = ld;
        e.rdata = rd;
        cpu_q.push_back(e);
    endtask

    // subordinate: apply last edge's handshakes, then drive this cycle's ready/valid
    initial begin
        int aw_cnt = 0, w_cnt = 0, ar_cnt = 0, b_cnt = 0, r_cnt = 0;
        logic aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0;
        logic aw_got = 0, w_got = 0, ar_got = 0;
        forever begin
            @(negedge ACLK);
            if (RESET) begin
                {aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt} = '0;
                {aw_hs, w_hs, b_hs, ar_hs, r_hs, aw_got, w_got, ar_got} = '0;
                {M_AXI_AWREADY, M_AXI_WREADY, M_AXI_ARREADY, M_AXI_BVALID, M_AXI_RVALID} = '0;
            end else begin
                if (aw_hs) aw_got = 1;
                if (w_hs) w_got = 1;
                if (ar_hs) ar_got = 1;
                if (b_hs) M_AXI_BVALID = 0;
                if (r_hs) M_AXI_RVALID = 0;
                M_AXI_AWREADY = M_AXI_AWVALID && aw_cnt >= aw_wait;
                aw_cnt = (M_AXI_AWVALID && !M_AXI_AWREADY) ? aw_cnt + 1 : 0;
                M_AXI_WREADY = M_AXI_WVALID && w_cnt >= w_wait;
                w_cnt = (M_AXI_WVALID && !M_AXI_WREADY) ? w_cnt + 1 : 0;
                M_AXI_ARREADY = M_AXI_ARVALID && ar_cnt >= ar_wait;
                ar_cnt = (M_AXI_ARVALID && !M_AXI_ARREADY) ? ar_cnt + 1 : 0;
                if (aw_got && w_got && !M_AXI_BVALID) begin
                    if (b_cnt >= b_wait) begin
                        M_AXI_BVALID = 1;
                        M_AXI_BRESP = bresp_c;
                        {aw_got, w_got, b_cnt} = '0;
                    end else b_cnt++;
                end
                if (ar_got && !M_AXI_RVALID) begin
                    if (r_cnt >= r_wait) begin
                        M_AXI_RVALID = 1;
                        M_AXI_RDATA = rdata_c;
                        M_AXI_RRESP = rresp_c;
                        ar_got = 0;
                        r_cnt = 0;
                    end else r_cnt++;
                end
                aw_hs = M_AXI_AWVALID && M_AXI_AWREADY;
                w_hs = M_AXI_WVALID && M_AXI_WREADY;
                ar_hs = M_AXI_ARVALID && M_AXI_ARREADY;
                b_hs = M_AXI_BVALID && M_AXI_BREADY;
                r_hs = M_AXI_RVALID && M_AXI_RREADY;
            end
        end
    end

    // monitor: pops the scoreboard whenever the DUT presents a handshake or a completion
    initial begin
        forever begin
            @(negedge ACLK);
            #1;
            if (!RESET) begin
                if (M_AXI_AWVALID) aw_cyc++;
                if (M_AXI_WVALID) w_cyc++;
                if (M_AXI_AWVALID && M_AXI_AWREADY) begin
                    if (aw_q.size() == 0) unexpected("aw");
                    else chk("awaddr", {32'd0, M_AXI_AWADDR}, {32'd0, aw_q.pop_front()});
                end
                if (M_AXI_WVALID && M_AXI_WREADY) begin
                    if (w_q.size() == 0) unexpected("w");
                    else chk("wdata_wstrb", {28'd0, M_AXI_WDATA, M_AXI_WSTRB}, {28'd0, w_q.pop_front()});
                end
                if (M_AXI_ARVALID && M_AXI_ARREADY) begin
                    if (ar_q.size() == 0) unexpected("ar");
                    else chk("araddr", {32'd0, M_AXI_ARADDR}, {32'd0, ar_q.pop_front()});
                end
                if ((CPU_WRSTB || CPU_RDSTB) && !CPU_BUSY) begin
                    if (cpu_q.size() == 0) unexpected("cpu_done");
                    else begin
                        cpu_t e;
                        e = cpu_q.pop_front();
                        chk("cpu_err", {63'd0, CPU_ERR}, {63'd0, e.err});
                        if (e.ld) chk("cpu_rdata", {32'd0, CPU_RDATA}, {32'd0, e.rdata});
                    end
                end
            end
        end
    end

    task automatic xfer(input logic wr, input logic rd, input logic [31:0] a, input logic [31:0] d,
                        input logic [1:0] sz, output int busy);
        bit done = 0;
        @(posedge ACLK);
        #1;
        {CPU_WRSTB, CPU_RDSTB, CPU_ADDR, CPU_WDATA, CPU_SIZE} = {wr, rd, a, d, sz};
        busy = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge ACLK);
            #2;
            if (!CPU_BUSY) begin
                done = 1;
                break;
            end
            busy++;
        end
        if (!done) unexpected("xfer_timeout");
        @(posedge ACLK);
        #1;
        {CPU_WRSTB, CPU_RDSTB} = 2'b00;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (2) @(posedge ACLK);
        #1;
        chk("reset_ctl", {57'd0, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID,
            M_AXI_RREADY, CPU_ERR, CPU_BUSY}, 64'd0);
        chk("reset_addr", {M_AXI_AWADDR, M_AXI_ARADDR}, 64'd0);
        chk("reset_data", {M_AXI_WDATA, CPU_RDATA}, 64'd0);
        chk("reset_strb_prot", {54'd0, M_AXI_WSTRB, M_AXI_AWPROT, M_AXI_ARPROT}, 64'd0);
        @(negedge ACLK);
        RESET = 0;

        aw_q.push_back(32'h100); w_q.push_back({32'hDEADBEEF, 4'hF}); exp_cpu(0, 0, 0);
        xfer(1, 0, 32'h100, 32'hDEADBEEF, 2'd2, n);
        chk("sw_busy", n, 2);

        aw_q.push_back(32'h203); w_q.push_back({32'h5A5A5A5A, 4'b1000}); exp_cpu(0, 0, 0);
        xfer(1, 0, 32'h203, 32'hFFFFFF5A, 2'd0, n);
        chk("sb_busy", n, 2);

        aw_wait = 3; aw_cyc = 0; w_cyc = 0;
        aw_q.push_back(32'h104); w_q.push_back({32'hCAFEF00D, 4'hF}); exp_cpu(0, 0, 0);
        xfer(1, 0, 32'h104, 32'hCAFEF00D, 2'd2, n);
        chk("slow_aw_cycles", aw_cyc, 4);
        chk("slow_w_cycles", w_cyc, 1);
        chk("slow_aw_busy", n, 5);
        aw_wait = 0;

        r_wait = 2; rdata_c = 32'h1234ABCD;
        ar_q.push_back(32'h302); exp_cpu(0, 1, 32'h00001234);
        xfer(0, 1, 32'h302, 0, 2'd1, n);
        chk("lh_busy", n, 4);
        chk("lh_hold", CPU_RDATA, 32'h00001234);
        r_wait = 0;

        exp_cpu(1, 1, 0);
        xfer(0, 1, 32'h401, 0, 2'd2, n);
        chk("mis_lw_busy", n, 0);

        ar_q.push_back(32'h301); exp_cpu(0, 1, 32'h000000AB);
        xfer(0, 1, 32'h301, 0, 2'd0, n);

        aw_q.push_back(32'h102); w_q.push_back({32'hBEEFBEEF, 4'b1100}); exp_cpu(0, 0, 0);
        xfer(1, 0, 32'h102, 32'h1111BEEF, 2'd1, n);

        rresp_c = 2'd2; rdata_c = 32'h89ABCDEF;
        ar_q.push_back(32'h400); exp_cpu(1, 1, 32'h89ABCDEF);
        xfer(0, 1, 32'h400, 0, 2'd2, n);
        rresp_c = 2'd0;

        bresp_c = 2'd3;
        aw_q.push_back(32'h108); w_q.push_back({32'h00000001, 4'hF}); exp_cpu(1, 0, 0);
        xfer(1, 0, 32'h108, 32'h00000001, 2'd2, n);
        bresp_c = 2'd0;

        exp_cpu(1, 0, 0);
        xfer(1, 0, 32'h101, 32'h1234, 2'd1, n);
        exp_cpu(1, 1, 0);
        xfer(0, 1, 32'h200, 0, 2'd3, n);

        aw_q.push_back(32'h10C); w_q.push_back({32'h01020304, 4'hF}); exp_cpu(0, 0, 0);
        xfer(1, 1, 32'h10C, 32'h01020304, 2'd2, n);

        ar_wait = 100;
        @(posedge ACLK);
        #1;
        {CPU_RDSTB, CPU_ADDR, CPU_SIZE} = {1'b1, 32'h500, 2'd2};
        @(negedge ACLK);
        @(negedge ACLK);
        #3;
        chk("rst_pre_arvalid", {63'd0, M_AXI_ARVALID}, 64'd1);
        CPU_RDSTB = 0;
        RESET = 1;
        #1;
        chk("rst_arvalid", {63'd0, M_AXI_ARVALID}, 64'd0);
        chk("rst_idle_busy", {63'd0, CPU_BUSY}, 64'd0);
        repeat (2) @(posedge ACLK);
        ar_wait = 0;
        @(negedge ACLK);
        RESET = 0;

        rdata_c = 32'h0BADF00D;
        ar_q.push_back(32'h504); exp_cpu(0, 1, 32'h0BADF00D);
        xfer(0, 1, 32'h504, 0, 2'd2, n);
        chk("post_rst_busy", n, 2);

        repeat (3) @(posedge ACLK);
        chk("queues_empty", aw_q.size() + w_q.size() + ar_q.size() + cpu_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
